// File: rtl/gemac_pfc_ctrl.sv
// gemac_pfc_ctrl
//   IEEE 802.1Qbb priority flow control for NUM_CLASSES traffic classes.
//   RX side: per-class pause timers loaded from decoded PFC frames. The
//   result is a registered per-class paused vector for the TX scheduler.
//   TX side: a three-state FSM (IDLE/REQ/HOLD) turns local per-class XOFF
//   requests into PFC frame requests (XOFF, XON release, periodic refresh).
//
// Handshake: tx_pfc_req is a level that rises together with stable
//   tx_pfc_enable_vec/tx_pfc_quanta and stays high until the frame
//   generator pulses tx_pfc_ack for one cycle; the request drops on the
//   following edge. Ack while no request is pending is ignored.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   pause_respect_en       1 = honour received PFC frames
//   rx_pfc_valid           1-cycle strobe, decoded PFC frame available
//   rx_pfc_enable_vec      class-enable vector of the received frame
//   rx_pfc_quanta          received quanta, class i at [i*QUANTA_W +: QUANTA_W]
//   class_paused           1 = TX must not start a frame on class i
//   xoff_req               level, local per-class XOFF requests
//   xoff_quanta            quanta advertised in outgoing XOFF
//   tx_pfc_req/ack         outgoing frame request / acceptance strobe
//   tx_pfc_enable_vec      enable vector of the outgoing frame
//   tx_pfc_quanta          quanta vector of the outgoing frame
//   fsm_state              debug view of the TX FSM state
module gemac_pfc_ctrl #(
   parameter int NUM_CLASSES    = 8,
   parameter int QUANTA_W       = 16,
   parameter int SLOT_CYCLES    = 64,
   parameter int REFRESH_MARGIN = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            pause_respect_en,
   input  logic                            rx_pfc_valid,
   input  logic [NUM_CLASSES-1:0]          rx_pfc_enable_vec,
   input  logic [NUM_CLASSES*QUANTA_W-1:0] rx_pfc_quanta,
   output logic [NUM_CLASSES-1:0]          class_paused,
   input  logic [NUM_CLASSES-1:0]          xoff_req,
   input  logic [QUANTA_W-1:0]             xoff_quanta,
   output logic                            tx_pfc_req,
   input  logic                            tx_pfc_ack,
   output logic [NUM_CLASSES-1:0]          tx_pfc_enable_vec,
   output logic [NUM_CLASSES*QUANTA_W-1:0] tx_pfc_quanta,
   output logic [1:0]                      fsm_state
);

   localparam int            PW    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [PW-1:0] P_TOP = PW'(SLOT_CYCLES - 1);
   // Refresh timer holds R*SLOT_CYCLES-1, R < 2**QUANTA_W, SLOT_CYCLES <= 2**PW.
   localparam int            TW    = QUANTA_W + PW;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // ---------------------------------------------------------------- RX timers
   logic [QUANTA_W-1:0]    q_cnt [NUM_CLASSES];
   logic [PW-1:0]          p_cnt [NUM_CLASSES];
   logic [QUANTA_W-1:0]    q_nxt [NUM_CLASSES];
   logic [PW-1:0]          p_nxt [NUM_CLASSES];
   logic [NUM_CLASSES-1:0] paused_nxt;

   always_comb begin
      paused_nxt = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         q_nxt[i] = q_cnt[i];
         p_nxt[i] = p_cnt[i];
         // Disable wins over a simultaneous strobe; a load wins over countdown.
         if (!pause_respect_en) begin
            q_nxt[i] = '0;
            p_nxt[i] = '0;
         end else if (rx_pfc_valid && rx_pfc_enable_vec[i]) begin
            q_nxt[i] = rx_pfc_quanta[i*QUANTA_W +: QUANTA_W];
            p_nxt[i] = P_TOP;
         end else if (q_cnt[i] != '0) begin
            if (p_cnt[i] == '0) begin
               q_nxt[i] = q_cnt[i] - QUANTA_W'(1);
               p_nxt[i] = P_TOP;
            end else begin
               p_nxt[i] = p_cnt[i] - PW'(1);
            end
         end
         // Registering the next-state test makes paused rise the cycle after
         // the strobe and last exactly Q*SLOT_CYCLES cycles.
         paused_nxt[i] = (q_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            q_cnt[i] <= '0;
            p_cnt[i] <= '0;
         end
         class_paused <= '0;
      end else begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            q_cnt[i] <= q_nxt[i];
            p_cnt[i] <= p_nxt[i];
         end
         class_paused <= paused_nxt;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   logic [1:0]                      state;
   logic [NUM_CLASSES-1:0]          n_mask;   // classes asserted by the pending frame
   logic [NUM_CLASSES-1:0]          s_mask;   // classes currently held in XOFF
   logic [TW-1:0]                   r_timer;
   logic                            start_req;
   logic [NUM_CLASSES-1:0]          n_new;
   logic [NUM_CLASSES*QUANTA_W-1:0] quanta_new;
   logic [QUANTA_W-1:0]             r_quanta;
   logic [TW-1:0]                   r_load;

   always_comb begin
      start_req = 1'b0;
      n_new     = xoff_req;
      case (state)
         ST_REQ: start_req = 1'b0;
         ST_HOLD: begin
            // A change in the requested set beats a coinciding refresh expiry.
            if (xoff_req != s_mask) begin
               start_req = 1'b1;
            end else if (r_timer == '0) begin
               start_req = 1'b1;
               n_new     = s_mask;
            end
         end
         default: start_req = (xoff_req != '0);
      endcase

      // Released classes (in S, not in N) go out as XON with quanta 0.
      quanta_new = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (n_new[i]) quanta_new[i*QUANTA_W +: QUANTA_W] = xoff_quanta;
      end

      r_quanta = (xoff_quanta > QUANTA_W'(REFRESH_MARGIN))
               ? xoff_quanta - QUANTA_W'(REFRESH_MARGIN) : QUANTA_W'(1);
      r_load   = TW'(r_quanta) * TW'(SLOT_CYCLES) - TW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         n_mask            <= '0;
         s_mask            <= '0;
         r_timer           <= '0;
         tx_pfc_req        <= 1'b0;
         tx_pfc_enable_vec <= '0;
         tx_pfc_quanta     <= '0;
      end else if (start_req) begin
         state             <= ST_REQ;
         n_mask            <= n_new;
         tx_pfc_req        <= 1'b1;
         tx_pfc_enable_vec <= n_new | s_mask;
         tx_pfc_quanta     <= quanta_new;
      end else if (state == ST_REQ) begin
         if (tx_pfc_ack) begin
            s_mask     <= n_mask;
            tx_pfc_req <= 1'b0;
            if (n_mask != '0) begin
               state   <= ST_HOLD;
               r_timer <= r_load;
            end else begin
               state   <= ST_IDLE;
            end
         end
      end else if (state == ST_HOLD) begin
         r_timer <= r_timer - TW'(1);
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_gemac_pfc_ctrl.sv
// Testbench for gemac_pfc_ctrl: table-driven RX vectors, hand-written
// multi-cycle sequences, then randomized traffic against a reference model
// that tracks remaining pause time in cycles and frame requests as events.
module tb_gemac_pfc_ctrl;

   localparam int NC   = 8;
   localparam int QW   = 16;
   localparam int SLOT = 64;
   localparam int MARG = 16;

   // ---------------------------------------------------------- clock / reset
   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            pause_respect_en = 1'b0;
   logic            rx_pfc_valid = 1'b0;
   logic [NC-1:0]   rx_pfc_enable_vec = '0;
   logic [NC*QW-1:0] rx_pfc_quanta = '0;
   logic [NC-1:0]   class_paused;
   logic [NC-1:0]   xoff_req = '0;
   logic [QW-1:0]   xoff_quanta = '0;
   logic            tx_pfc_req;
   logic            tx_pfc_ack = 1'b0;
   logic [NC-1:0]   tx_pfc_enable_vec;
   logic [NC*QW-1:0] tx_pfc_quanta;
   logic [1:0]      fsm_state;

   always #5 clk = ~clk;

   gemac_pfc_ctrl #(
      .NUM_CLASSES(NC), .QUANTA_W(QW), .SLOT_CYCLES(SLOT), .REFRESH_MARGIN(MARG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pause_respect_en(pause_respect_en),
      .rx_pfc_valid(rx_pfc_valid), .rx_pfc_enable_vec(rx_pfc_enable_vec),
      .rx_pfc_quanta(rx_pfc_quanta), .class_paused(class_paused),
      .xoff_req(xoff_req), .xoff_quanta(xoff_quanta), .tx_pfc_req(tx_pfc_req),
      .tx_pfc_ack(tx_pfc_ack), .tx_pfc_enable_vec(tx_pfc_enable_vec),
      .tx_pfc_quanta(tx_pfc_quanta), .fsm_state(fsm_state)
   );

   // ---------------------------------------------------------- scoreboard
   int checks = 0;
   int failures = 0;
   logic [NC*QW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [NC*QW-1:0] act,
                      input logic [NC*QW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NC*QW-1:0] qvec(input logic [NC-1:0] mask,
                                             input logic [QW-1:0] q);
      logic [NC*QW-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++) if (mask[i]) v[i*QW +: QW] = q;
      return v;
   endfunction

   // ---------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      pause_respect_en = 1'b1;
      rx_pfc_valid = 1'b0;
      rx_pfc_enable_vec = '0;
      rx_pfc_quanta = '0;
      xoff_req = '0;
      xoff_quanta = '0;
      tx_pfc_ack = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic rx_strobe(input logic [NC-1:0] en, input logic [NC*QW-1:0] q);
      rx_pfc_valid = 1'b1;
      rx_pfc_enable_vec = en;
      rx_pfc_quanta = q;
      step();
      rx_pfc_valid = 1'b0;
      rx_pfc_enable_vec = '0;
   endtask

   task automatic ack_pulse();
      tx_pfc_ack = 1'b1;
      step();
      tx_pfc_ack = 1'b0;
   endtask

   // ---------------------------------------------------------- reference model
   int          m_rem[NC];          // remaining paused cycles per class
   bit          m_req;
   bit          m_hold;
   int          m_left;             // cycles left before a refresh is due
   logic [NC-1:0] m_n, m_s, m_en;
   logic [NC*QW-1:0] m_qv;

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_rem[i] = 0;
      m_req = 0; m_hold = 0; m_left = 0;
      m_n = '0; m_s = '0; m_en = '0; m_qv = '0;
   endtask

   task automatic model_step(input bit pre, input bit valid, input logic [NC-1:0] en,
                             input logic [NC*QW-1:0] q, input logic [NC-1:0] xr,
                             input logic [QW-1:0] xq, input bit ack);
      bit start;
      logic [NC-1:0] nn;
      int r;
      for (int i = 0; i < NC; i++) begin
         if (!pre) m_rem[i] = 0;
         else if (valid && en[i]) m_rem[i] = int'(q[i*QW +: QW]) * SLOT;
         else if (m_rem[i] > 0) m_rem[i]--;
      end
      start = 0;
      nn = xr;
      if (m_req) begin
         if (ack) begin
            m_s = m_n;
            m_req = 0;
            m_hold = (m_n != '0);
            r = int'(xq) - MARG;
            if (r < 1) r = 1;
            m_left = r * SLOT;
         end
      end else if (m_hold) begin
         if (xr != m_s) start = 1;
         else begin
            m_left--;
            if (m_left == 0) begin
               start = 1;
               nn = m_s;
            end
         end
      end else if (xr != '0) begin
         start = 1;
      end
      if (start) begin
         m_n = nn;
         m_en = nn | m_s;
         m_qv = qvec(nn, xq);
         m_req = 1;
         m_hold = 0;
      end
   endtask

   // ---------------------------------------------------------- RX vector table
   typedef struct {
      logic          pre;
      logic          valid;
      logic [NC-1:0] en;
      logic [QW-1:0] q;
      logic [NC-1:0] exp_paused;
   } rx_vec_t;

   rx_vec_t tbl[10];

   // ---------------------------------------------------------- test body
   initial begin
      int cnt;
      bit seen_high;
      bit pre_r, val_r, ack_r;
      logic [NC-1:0] en_r, xr_r;
      logic [NC*QW-1:0] q_r;
      logic [QW-1:0] xq_r;

      tbl[0] = '{1'b1, 1'b1, 8'h04, 16'd5, 8'h04};
      tbl[1] = '{1'b1, 1'b1, 8'h01, 16'd5, 8'h05};
      tbl[2] = '{1'b1, 1'b1, 8'h04, 16'd0, 8'h01};
      tbl[3] = '{1'b1, 1'b1, 8'hFF, 16'd0, 8'h00};
      tbl[4] = '{1'b1, 1'b1, 8'hA0, 16'd7, 8'hA0};
      tbl[5] = '{1'b0, 1'b1, 8'h0F, 16'd9, 8'h00};
      tbl[6] = '{1'b1, 1'b0, 8'h00, 16'd0, 8'h00};
      tbl[7] = '{1'b1, 1'b1, 8'h20, 16'd1, 8'h20};
      tbl[8] = '{1'b1, 1'b0, 8'h00, 16'd0, 8'h20};
      tbl[9] = '{1'b1, 1'b1, 8'h00, 16'd3, 8'h20};

      // Reset state
      do_reset();
      chk("reset_paused", NC*QW'(class_paused), '0);
      chk("reset_req", NC*QW'(tx_pfc_req), '0);
      chk("reset_en", NC*QW'(tx_pfc_enable_vec), '0);
      chk("reset_quanta", tx_pfc_quanta, '0);

      // Table-driven RX vectors
      for (int k = 0; k < 10; k++) begin
         pause_respect_en = tbl[k].pre;
         rx_pfc_valid = tbl[k].valid;
         rx_pfc_enable_vec = tbl[k].en;
         rx_pfc_quanta = {NC{tbl[k].q}};
         step();
         chk($sformatf("tbl_%0d_paused", k), NC*QW'(class_paused),
             NC*QW'(tbl[k].exp_paused));
      end
      rx_pfc_valid = 1'b0;

      // 3 quanta -> exactly 192 paused cycles starting after the strobe
      do_reset();
      rx_strobe(8'h04, qvec(8'h04, 16'd3));
      chk("t1_first", NC*QW'(class_paused), NC*QW'(8'h04));
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
         if (class_paused[2]) cnt++;
         step();
      end
      chk("t1_len", NC*QW'(cnt), NC*QW'(192));

      // XON on class 2; other-class strobe leaves class 2 untouched
      do_reset();
      rx_strobe(8'h04, qvec(8'h04, 16'd100));
      for (int k = 0; k < 10; k++) step();
      rx_strobe(8'h01, {NC{16'd5}});
      chk("t2_other_class", NC*QW'(class_paused), NC*QW'(8'h05));
      rx_strobe(8'h04, '0);
      chk("t2_xon", NC*QW'(class_paused), NC*QW'(8'h01));

      // Disable beats a simultaneous strobe
      do_reset();
      rx_strobe(8'h20, qvec(8'h20, 16'd50));
      chk("t3_loaded", NC*QW'(class_paused), NC*QW'(8'h20));
      pause_respect_en = 1'b0;
      rx_strobe(8'h20, qvec(8'h20, 16'd50));
      chk("t3_cleared", NC*QW'(class_paused), '0);
      pause_respect_en = 1'b1;
      step();
      chk("t3_discarded", NC*QW'(class_paused), '0);

      // XOFF request and refresh after 24*64 cycles
      do_reset();
      xoff_req = 8'h02;
      xoff_quanta = 16'd40;
      step();
      chk("t4_req", NC*QW'(tx_pfc_req), NC*QW'(1));
      chk("t4_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(8'h02));
      chk("t4_quanta", tx_pfc_quanta, qvec(8'h02, 16'd40));
      ack_pulse();
      cnt = 0;
      while (!tx_pfc_req && cnt < 3000) begin
         cnt++;
         step();
      end
      chk("t4_refresh_gap", NC*QW'(cnt), NC*QW'(1536));
      chk("t4_refresh_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(8'h02));
      chk("t4_refresh_quanta", tx_pfc_quanta, qvec(8'h02, 16'd40));

      // Release -> XON with quanta 0, then back to idle
      ack_pulse();
      xoff_req = 8'h00;
      step();
      chk("t5_req", NC*QW'(tx_pfc_req), NC*QW'(1));
      chk("t5_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(8'h02));
      chk("t5_quanta", tx_pfc_quanta, '0);
      ack_pulse();
      seen_high = 0;
      for (int k = 0; k < 2000; k++) begin
         if (tx_pfc_req) seen_high = 1;
         step();
      end
      chk("t5_idle", NC*QW'(seen_high), '0);

      // Change during REQ evaluated after ack; async reset mid-REQ
      do_reset();
      rx_strobe(8'h08, qvec(8'h08, 16'd20));
      xoff_req = 8'h02;
      xoff_quanta = 16'd40;
      step();
      xoff_req = 8'h06;
      step();
      chk("t6_stable_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(8'h02));
      chk("t6_stable_req", NC*QW'(tx_pfc_req), NC*QW'(1));
      ack_pulse();
      chk("t6_drop", NC*QW'(tx_pfc_req), '0);
      step();
      chk("t6_second_req", NC*QW'(tx_pfc_req), NC*QW'(1));
      chk("t6_second_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(8'h06));
      chk("t6_second_quanta", tx_pfc_quanta, qvec(8'h06, 16'd40));
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_req", NC*QW'(tx_pfc_req), '0);
      chk("t6_rst_en", NC*QW'(tx_pfc_enable_vec), '0);
      chk("t6_rst_quanta", tx_pfc_quanta, '0);
      chk("t6_rst_paused", NC*QW'(class_paused), '0);
      do_reset();

      // Randomized traffic against the reference model
      model_reset();
      for (int k = 0; k < 15000; k++) begin
         pause_respect_en = ($urandom_range(0, 49) != 0);
         rx_pfc_valid = ($urandom_range(0, 19) == 0);
         rx_pfc_enable_vec = NC'($urandom);
         for (int i = 0; i < NC; i++) rx_pfc_quanta[i*QW +: QW] = QW'($urandom_range(0, 6));
         if ($urandom_range(0, 199) == 0) begin
            xoff_req = ($urandom_range(0, 2) == 0) ? '0 : NC'($urandom);
            xoff_quanta = QW'($urandom_range(0, 20));
         end
         tx_pfc_ack = ($urandom_range(0, 3) == 0);
         pre_r = pause_respect_en; val_r = rx_pfc_valid; en_r = rx_pfc_enable_vec;
         q_r = rx_pfc_quanta; xr_r = xoff_req; xq_r = xoff_quanta; ack_r = tx_pfc_ack;
         step();
         model_step(pre_r, val_r, en_r, q_r, xr_r, xq_r, ack_r);
         for (int i = 0; i < NC; i++) begin
            exp_q.push_back(NC*QW'(m_rem[i] > 0));
            chk($sformatf("rnd_paused%0d", i), NC*QW'(class_paused[i]), exp_q.pop_front());
         end
         chk("rnd_req", NC*QW'(tx_pfc_req), NC*QW'(m_req));
         if (m_req) begin
            chk("rnd_en", NC*QW'(tx_pfc_enable_vec), NC*QW'(m_en));
            chk("rnd_quanta", tx_pfc_quanta, m_qv);
         end
      end

      // ---------------------------------------------------------- report
      $display("final fsm_state=%0d", fsm_state);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
